nav_ctrl: RTL and testbench
===========================

NAV_CTRL -- requirements
Module: nav_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency; informational only, no logic depends on it.
REQ-002 Parameter NEAR_CM, default 9'd20, distance (cm) below which speed is SLOW.
REQ-003 Parameter FAR_CM, default 9'd60, distance (cm) at or above which speed is FAST.
REQ-004 Parameter STUCK_CM, default 9'd8, distance (cm) below which a sample counts as blocked.
REQ-005 Parameter STUCK_N, default 4, consecutive blocked samples that trigger recovery.
REQ-006 Parameter TURN_CYCLES, default 32'd50_000_000, recovery duration in clk cycles.
REQ-007 Parameter TIMEOUT_CYCLES, default 32'd10_000_000, maximum clk cycles allowed between dist_valid pulses.
REQ-008 Parameter DEB_CYCLES, default 20'd1_000_000, bump debounce stability window in clk cycles.
REQ-009 clk  input  1  system clock, all state on rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 enable  input  1  run request; 0 forces IDLE.
REQ-012 dist_cm  input  9  ultrasonic range in cm; sampled only when dist_valid=1.
REQ-013 dist_valid  input  1  single-cycle strobe qualifying dist_cm.
REQ-014 bump_raw  input  1  asynchronous bumper switch, active-high, bouncing.
REQ-015 speed  output  2  drive command to motor stage: 00 SLOW, 01 MID, 10 FAST, 11 STOP; registered.
REQ-016 is_stuck  output  1  recovery (turn) command to motor stage; registered.
REQ-017 state  output  2  current FSM state, for debug LEDs: 00 IDLE, 01 CRUISE, 10 TURN, 11 FAULT.

Function
REQ-018 The FSM SHALL have four states: IDLE, CRUISE, TURN, FAULT.
REQ-019 IDLE: speed=11, is_stuck=0; enable=1 → CRUISE on the next cycle.
REQ-020 enable=0 in any state SHALL force IDLE on the next cycle, clear all counters, and take priority over every other transition.
REQ-021 CRUISE: on each dist_valid, speed SHALL update on the next edge: dist_cm<NEAR_CM → 00; NEAR_CM≤dist_cm<FAR_CM → 01; dist_cm≥FAR_CM → 10 (1-cycle latency).
REQ-022 On entry to CRUISE from IDLE or TURN, speed SHALL be 00 until the first dist_valid.
REQ-023 Blocked counter: increment (saturating at STUCK_N) on a valid sample with dist_cm<STUCK_CM; clear on a valid sample with dist_cm≥STUCK_CM; hold when dist_valid=0.
REQ-024 CRUISE → TURN when the blocked counter reaches STUCK_N, or on the rising edge of debounced bump; bump takes effect the cycle after its debounced edge.
REQ-025 TURN: is_stuck=1, speed=00 for exactly TURN_CYCLES cycles, then → CRUISE; dist_valid and bump are ignored, and the blocked counter is cleared on entry.
REQ-026 Watchdog counter SHALL count cycles since the last dist_valid in CRUISE; reaching TIMEOUT_CYCLES → FAULT.
REQ-027 FAULT: speed=11, is_stuck=0; dist_valid=1 → CRUISE with speed decoded from that sample per REQ-021.
REQ-028 When dist_valid and a debounced bump edge occur in the same cycle in CRUISE, TURN SHALL win.
REQ-029 Threshold comparisons SHALL be unsigned 9-bit; counters SHALL be 32-bit and never wrap (saturate or clear).

Reset
REQ-030 reset=1 SHALL asynchronously set state=IDLE, speed=11, is_stuck=0, all counters=0, and debouncer output=0.
REQ-031 Reset asserted mid-TURN SHALL abort the turn immediately; after release the block restarts from IDLE.
REQ-032 bump_raw SHALL pass through a 2-flop synchronizer, reset to 0.

Structure
REQ-033 Speed encodings (SLOW/MID/FAST/STOP) and state encodings SHALL be localparams in a shared package, nav_pkg, that the motor stage also uses.
REQ-034 Debounce SHALL be a sub-module, bump_debounce (synchronizer plus stability counter; output changes only after DEB_CYCLES cycles of a stable input).
REQ-035 Target size: 150–300 lines RTL total.

Verification (bench parameters: TURN_CYCLES=16, TIMEOUT_CYCLES=64, DEB_CYCLES=4, STUCK_N=4)
REQ-036 Reset, then enable=1, then dist 100 valid → speed 11, then 00, then 10 one cycle after the strobe; is_stuck=0 throughout.
REQ-037 Valid samples 30, 19, 20, 59, 60 → speed 01, 00, 01, 01, 10 (threshold boundaries).
REQ-038 Samples 5, 5, 5, 9, 5, 5, 5, 5 → no TURN after the 9; TURN entered after the 8th sample; is_stuck=1 for exactly 16 cycles; speed=00 until the next valid sample.
REQ-039 bump_raw toggling every cycle for 10 cycles then held at 1 → TURN entered only after 4 stable cycles plus synchronizer delay; the glitches alone never trigger TURN.
REQ-040 No dist_valid for 64 cycles in CRUISE → FAULT with speed=11; then dist 40 valid → CRUISE with speed=01.
REQ-041 Reset pulsed mid-TURN, and separately enable dropped mid-TURN → is_stuck=0 and speed=11 immediately on reset, or on the next cycle for enable; state=IDLE.

Source files
------------

// File: rtl/nav_pkg.sv
// nav_pkg: speed and state encodings shared by nav_ctrl and the motor stage.
package nav_pkg;
   localparam logic [1:0] SPD_SLOW = 2'b00;
   localparam logic [1:0] SPD_MID  = 2'b01;
   localparam logic [1:0] SPD_FAST = 2'b10;
   localparam logic [1:0] SPD_STOP = 2'b11;
   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_CRUISE = 2'b01;
   localparam logic [1:0] ST_TURN   = 2'b10;
   localparam logic [1:0] ST_FAULT  = 2'b11;
   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_CRUISE = ST_CRUISE,
      S_TURN   = ST_TURN,
      S_FAULT  = ST_FAULT
   } nav_state_t;
   function automatic logic [1:0] speed_of(input logic [8:0] d, input logic [8:0] near, input logic [8:0] far);
      return d < near ? SPD_SLOW : d < far ? SPD_MID : SPD_FAST;
   endfunction
endpackage

// File: rtl/nav_ctrl_if.sv
// nav_ctrl_if: sensor/bumper inputs and motor-stage commands of nav_ctrl.
interface nav_ctrl_if;
   logic       enable;
   logic [8:0] dist_cm;
   logic       dist_valid;
   logic       bump_raw;
   logic [1:0] speed;
   logic       is_stuck;
   logic [1:0] state;
   modport master (output enable, dist_cm, dist_valid, bump_raw, input speed, is_stuck, state);
   modport slave  (input enable, dist_cm, dist_valid, bump_raw, output speed, is_stuck, state);
endinterface

// File: rtl/bump_debounce.sv
// bump_debounce: 2-flop synchronizer plus stability counter for the bumper switch.
module bump_debounce #(
   parameter logic [19:0] DEB_CYCLES = 20'd1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic deb
);
   logic        s1, s2;
   logic [31:0] cnt;
   // deb follows s2 only after s2 has disagreed with it for DEB_CYCLES straight cycles
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         cnt <= '0;
         deb <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == deb) cnt <= '0;
         else if (cnt >= 32'(DEB_CYCLES) - 32'd1) begin
            deb <= s2;
            cnt <= '0;
         end else cnt <= cnt + 32'd1;
      end
endmodule

// File: rtl/nav_ctrl.sv
// nav_ctrl: obstacle-avoidance FSM choosing motor speed and turn recovery
// from ultrasonic range samples, a debounced bumper and a sample watchdog.
module nav_ctrl
   import nav_pkg::*;
#(
   parameter int          CLK_HZ         = 100_000_000,
   parameter logic [8:0]  NEAR_CM        = 9'd20,
   parameter logic [8:0]  FAR_CM         = 9'd60,
   parameter logic [8:0]  STUCK_CM       = 9'd8,
   parameter int          STUCK_N        = 4,
   parameter logic [31:0] TURN_CYCLES    = 32'd50_000_000,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000,
   parameter logic [19:0] DEB_CYCLES     = 20'd1_000_000
) (
   input logic       clk,
   input logic       reset,
   nav_ctrl_if.slave bus
);
   if (CLK_HZ <= 0) begin : g_clk_chk
      $error("CLK_HZ must be positive");
   end
   nav_state_t  st;
   logic [1:0]  spd, dspd;
   logic        stk, deb, deb_q, bump_edge;
   logic [31:0] blk_cnt, blk_nxt, wd_cnt, turn_cnt;
   bump_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.bump_raw),
      .deb   (deb)
   );
   assign bump_edge = deb & ~deb_q;
   assign dspd      = speed_of(bus.dist_cm, NEAR_CM, FAR_CM);
   assign blk_nxt   = bus.dist_cm < STUCK_CM ? (blk_cnt >= 32'(STUCK_N) ? blk_cnt : blk_cnt + 32'd1) : '0;
   assign bus.speed    = spd;
   assign bus.is_stuck = stk;
   assign bus.state    = st;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st       <= S_IDLE;
         spd      <= SPD_STOP;
         stk      <= 1'b0;
         blk_cnt  <= '0;
         wd_cnt   <= '0;
         turn_cnt <= '0;
         deb_q    <= 1'b0;
      end else begin
         deb_q <= deb;
         if (!bus.enable) begin
            st       <= S_IDLE;
            spd      <= SPD_STOP;
            stk      <= 1'b0;
            blk_cnt  <= '0;
            wd_cnt   <= '0;
            turn_cnt <= '0;
         end else case (st)
            S_IDLE: begin
               st  <= S_CRUISE;
               spd <= SPD_SLOW;
            end
            S_CRUISE:
               // a bump edge wins over a sample arriving in the same cycle
               if (bump_edge || (bus.dist_valid && blk_nxt >= 32'(STUCK_N))) begin
                  st       <= S_TURN;
                  spd      <= SPD_SLOW;
                  stk      <= 1'b1;
                  blk_cnt  <= '0;
                  wd_cnt   <= '0;
                  turn_cnt <= '0;
               end else if (bus.dist_valid) begin
                  spd     <= dspd;
                  blk_cnt <= blk_nxt;
                  wd_cnt  <= '0;
               end else if (wd_cnt >= TIMEOUT_CYCLES - 32'd1) begin
                  st     <= S_FAULT;
                  spd    <= SPD_STOP;
                  wd_cnt <= '0;
               end else wd_cnt <= wd_cnt + 32'd1;
            S_TURN:
               if (turn_cnt >= TURN_CYCLES - 32'd1) begin
                  st       <= S_CRUISE;
                  stk      <= 1'b0;
                  turn_cnt <= '0;
               end else turn_cnt <= turn_cnt + 32'd1;
            S_FAULT:
               if (bus.dist_valid) begin
                  st  <= S_CRUISE;
                  spd <= dspd;
               end
            default: st <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_nav_ctrl.sv
// tb_nav_ctrl: directed vector table plus hand sequences for debounce,
// turn length, watchdog and mid-turn abort.
module tb_nav_ctrl;
   import nav_pkg::*;
   typedef struct {
      logic       v;
      logic [8:0] d;
      logic [1:0] spd;
      logic       stk;
      logic [1:0] st;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t tbl[$];
   always #5 clk = ~clk;
   nav_ctrl_if bus();
   nav_ctrl #(
      .TURN_CYCLES    (32'd16),
      .TIMEOUT_CYCLES (32'd64),
      .DEB_CYCLES     (20'd4),
      .STUCK_N        (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask
   task automatic check_out(input string name, input logic [1:0] spd, input logic stk, input logic [1:0] st);
      check({name, ".speed"}, 32'(bus.speed), 32'(spd));
      check({name, ".is_stuck"}, 32'(bus.is_stuck), 32'(stk));
      check({name, ".state"}, 32'(bus.state), 32'(st));
   endtask
   task automatic tick(input logic v, input logic [8:0] d);
      bus.dist_valid = v;
      bus.dist_cm    = d;
      @(posedge clk);
      #1;
      bus.dist_valid = 1'b0;
   endtask
   task automatic add(input logic v, input logic [8:0] d, input logic [1:0] spd, input logic stk, input logic [1:0] st);
      vec_t e;
      e.v = v; e.d = d; e.spd = spd; e.stk = stk; e.st = st;
      tbl.push_back(e);
   endtask
   initial begin
      int n;
      bit found;
      add(0, 0,   SPD_SLOW, 0, ST_CRUISE);
      add(1, 100, SPD_FAST, 0, ST_CRUISE);
      add(1, 30,  SPD_MID,  0, ST_CRUISE);
      add(1, 19,  SPD_SLOW, 0, ST_CRUISE);
      add(1, 20,  SPD_MID,  0, ST_CRUISE);
      add(1, 59,  SPD_MID,  0, ST_CRUISE);
      add(1, 60,  SPD_FAST, 0, ST_CRUISE);
      add(0, 0,   SPD_FAST, 0, ST_CRUISE);
      add(1, 5,   SPD_SLOW, 0, ST_CRUISE);
      add(1, 5,   SPD_SLOW, 0, ST_CRUISE);
      add(1, 5,   SPD_SLOW, 0, ST_CRUISE);
      add(1, 9,   SPD_SLOW, 0, ST_CRUISE);
      add(1, 5,   SPD_SLOW, 0, ST_CRUISE);
      add(1, 5,   SPD_SLOW, 0, ST_CRUISE);
      add(1, 5,   SPD_SLOW, 0, ST_CRUISE);
      add(1, 5,   SPD_SLOW, 1, ST_TURN);
      for (int i = 0; i < 15; i++) add(1, 100, SPD_SLOW, 1, ST_TURN);
      add(0, 0,   SPD_SLOW, 0, ST_CRUISE);
      add(1, 100, SPD_FAST, 0, ST_CRUISE);
      bus.enable = 1'b0;
      bus.dist_valid = 1'b0;
      bus.dist_cm = '0;
      bus.bump_raw = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", SPD_STOP, 0, ST_IDLE);
      reset = 1'b0;
      tick(0, 0);
      check_out("idle_hold", SPD_STOP, 0, ST_IDLE);
      bus.enable = 1'b1;
      foreach (tbl[i]) begin
         tick(tbl[i].v, tbl[i].d);
         check_out($sformatf("vec%0d", i), tbl[i].spd, tbl[i].stk, tbl[i].st);
      end
      // bouncing bumper must not trigger a turn
      for (int i = 0; i < 10; i++) begin
         bus.bump_raw = (i % 2 == 0);
         tick(0, 0);
         check($sformatf("glitch%0d.state", i), 32'(bus.state), 32'(ST_CRUISE));
      end
      // 2 sync flops + 4 stable cycles + 1 edge-detect cycle
      bus.bump_raw = 1'b1;
      n = 0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(0, 0);
         n++;
         found = (bus.state == ST_TURN);
      end
      check("bump_latency", 32'(n), 32'd7);
      check_out("bump_turn", SPD_SLOW, 1, ST_TURN);
      bus.bump_raw = 1'b0;
      n = 1;
      for (int i = 0; i < 40 && bus.is_stuck; i++) begin
         tick(0, 0);
         if (bus.is_stuck) n++;
      end
      check("turn_len", 32'(n), 32'd16);
      check_out("turn_exit", SPD_SLOW, 0, ST_CRUISE);
      tick(1, 100);
      check_out("pre_wd", SPD_FAST, 0, ST_CRUISE);
      n = 0;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick(0, 0);
         n++;
         found = (bus.state == ST_FAULT);
      end
      check("wd_latency", 32'(n), 32'd64);
      check_out("fault", SPD_STOP, 0, ST_FAULT);
      tick(1, 40);
      check_out("fault_exit", SPD_MID, 0, ST_CRUISE);
      repeat (4) tick(1, 5);
      check_out("turn_a", SPD_SLOW, 1, ST_TURN);
      repeat (3) tick(0, 0);
      reset = 1'b1;
      #1;
      check_out("reset_mid_turn", SPD_STOP, 0, ST_IDLE);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(0, 0);
      check_out("restart", SPD_SLOW, 0, ST_CRUISE);
      repeat (4) tick(1, 5);
      check_out("turn_b", SPD_SLOW, 1, ST_TURN);
      repeat (3) tick(0, 0);
      bus.enable = 1'b0;
      tick(0, 0);
      check_out("disable_mid_turn", SPD_STOP, 0, ST_IDLE);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
